// File: rtl/hub_fifo_pkg.sv
// Shared slot layout for the hub final-FIFO link (packer and dispatcher).
// Slot = {valid, dest, payload}; slot s sits at word bits [s*SLOT_WIDTH +: SLOT_WIDTH].
package hub_fifo_pkg;

   localparam int DEF_HUB_FIFO_WIDTH          = 13;
   localparam int DEF_HUB_FIFO_PHYSICAL_WIDTH = 128;
   localparam int DEF_FIFO_IDWIDTH            = 2;
   localparam int DEF_FIFO_COUNT              = 3;

   typedef enum logic {
      DISP_IDLE,
      DISP_DISPATCH
   } dispatch_state_t;

   typedef struct packed {
      logic                          valid;
      logic [DEF_FIFO_IDWIDTH-1:0]   dest;
      logic [DEF_HUB_FIFO_WIDTH-1:0] payload;
   } slot_t;

   function automatic int slot_width_f(input int hub_fifo_width, input int fifo_idwidth);
      return 1 + fifo_idwidth + hub_fifo_width;
   endfunction

   function automatic int slots_f(input int physical_width, input int hub_fifo_width,
                                  input int fifo_idwidth);
      return physical_width / slot_width_f(hub_fifo_width, fifo_idwidth);
   endfunction

   localparam int SLOT_PAYLOAD_LSB = 0;

   function automatic int slot_dest_lsb(input int hub_fifo_width);
      return hub_fifo_width;
   endfunction

   function automatic int slot_valid_bit(input int hub_fifo_width, input int fifo_idwidth);
      return hub_fifo_width + fifo_idwidth;
   endfunction

   // The SC channel is addressed by the first dest code past the master channels.
   function automatic int sc_dest_f(input int fifo_count);
      return fifo_count;
   endfunction

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Purpose: index of the lowest set bit of vec, plus an any-bit-set flag.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module lowest_set_bit_encoder #(
   parameter int WIDTH     = 8,
   parameter int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]     vec,
   output logic [IDX_WIDTH-1:0] idx,
   output logic                 any
);

   always_comb begin
      idx = '0;
      any = 1'b0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_WIDTH'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/final_dispatch_unit.sv
// Purpose: unpack final-FIFO words and deliver each valid slot in order to its master/SC FIFO.
// Latency: first slot valid one cycle after word accept; one cycle per slot when unstalled.
// Backpressure: word ready only in IDLE; a stalled slot holds valid/data and blocks later slots.
module final_dispatch_unit
   import hub_fifo_pkg::*;
#(
   parameter int HUB_FIFO_WIDTH          = DEF_HUB_FIFO_WIDTH,
   parameter int HUB_FIFO_PHYSICAL_WIDTH = DEF_HUB_FIFO_PHYSICAL_WIDTH,
   parameter int FIFO_IDWIDTH            = DEF_FIFO_IDWIDTH,
   parameter int FIFO_COUNT              = DEF_FIFO_COUNT
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [HUB_FIFO_PHYSICAL_WIDTH-1:0]   final_fifo_in_data,
   input  logic                                 final_fifo_in_valid,
   output logic                                 final_fifo_in_ready,
   output logic [HUB_FIFO_WIDTH*FIFO_COUNT-1:0] master_fifo_in_data_vector,
   output logic [FIFO_COUNT-1:0]                master_fifo_in_valid_vector,
   input  logic [FIFO_COUNT-1:0]                master_fifo_in_ready_vector,
   output logic [HUB_FIFO_WIDTH-1:0]            sc_fifo_in_data,
   output logic                                 sc_fifo_in_valid,
   input  logic                                 sc_fifo_in_ready,
   output logic                                 has_flying_messages,
   output logic [7:0]                           dropped_count
);

   localparam int SW        = slot_width_f(HUB_FIFO_WIDTH, FIFO_IDWIDTH);
   localparam int SLOTS     = slots_f(HUB_FIFO_PHYSICAL_WIDTH, HUB_FIFO_WIDTH, FIFO_IDWIDTH);
   localparam int FW        = FIFO_IDWIDTH + HUB_FIFO_WIDTH;
   localparam int IW        = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int DEST_LSB  = slot_dest_lsb(HUB_FIFO_WIDTH);
   localparam int VALID_BIT = slot_valid_bit(HUB_FIFO_WIDTH, FIFO_IDWIDTH);
   localparam logic [FIFO_IDWIDTH-1:0] SC_DEST = FIFO_IDWIDTH'(sc_dest_f(FIFO_COUNT));

   dispatch_state_t         state_q, state_d;
   logic [SLOTS-1:0]        pending_q, pending_d;
   logic [SLOTS-1:0][FW-1:0] hold_q, hold_d;
   logic [7:0]              dropped_q, dropped_d;

   logic [SLOTS-1:0]         in_slot_valid;
   logic [SLOTS-1:0][FW-1:0] in_slot_fields;
   logic [IW-1:0]            sel_idx;
   logic                     sel_any;
   logic [SLOTS-1:0]         sel_onehot;
   logic [FW-1:0]            sel_fields;
   logic [FIFO_IDWIDTH-1:0]  sel_dest;
   logic [HUB_FIFO_WIDTH-1:0] sel_payload;
   logic                     active;
   logic                     dest_bad;
   logic [FIFO_COUNT-1:0]    master_valid;
   logic                     sc_valid;
   logic                     deliver_ok;

   // The valid bit is kept apart from the stored fields; pending carries it.
   always_comb begin
      in_slot_valid  = '0;
      in_slot_fields = '0;
      for (int s = 0; s < SLOTS; s++) begin
         in_slot_valid[s]  = final_fifo_in_data[s*SW + VALID_BIT];
         in_slot_fields[s] = final_fifo_in_data[s*SW + SLOT_PAYLOAD_LSB +: FW];
      end
   end

   lowest_set_bit_encoder #(
      .WIDTH     (SLOTS),
      .IDX_WIDTH (IW)
   ) u_sel_enc (
      .vec (pending_q),
      .idx (sel_idx),
      .any (sel_any)
   );

   assign sel_onehot  = pending_q & (~pending_q + SLOTS'(1));
   assign sel_fields  = hold_q[sel_idx];
   assign sel_dest    = sel_fields[DEST_LSB +: FIFO_IDWIDTH];
   assign sel_payload = sel_fields[HUB_FIFO_WIDTH-1:0];
   assign active      = (state_q == DISP_DISPATCH) && sel_any;
   assign dest_bad    = sel_dest > SC_DEST;

   always_comb begin
      master_valid = '0;
      for (int i = 0; i < FIFO_COUNT; i++) begin
         master_valid[i] = active && (sel_dest == FIFO_IDWIDTH'(i));
      end
   end

   assign sc_valid   = active && (sel_dest == SC_DEST);
   assign deliver_ok = dest_bad || (|(master_valid & master_fifo_in_ready_vector)) ||
                       (sc_valid && sc_fifo_in_ready);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      hold_d    = hold_q;
      dropped_d = dropped_q;
      case (state_q)
         DISP_IDLE: begin
            if (final_fifo_in_valid) begin
               hold_d    = in_slot_fields;
               pending_d = in_slot_valid;
               if (|in_slot_valid) begin
                  state_d = DISP_DISPATCH;
               end
            end
         end
         DISP_DISPATCH: begin
            if (!sel_any) begin
               state_d = DISP_IDLE;
            end else if (deliver_ok) begin
               pending_d = pending_q & ~sel_onehot;
               if (dest_bad && (dropped_q != 8'hFF)) begin
                  dropped_d = dropped_q + 8'd1;
               end
               if ((pending_q & ~sel_onehot) == '0) begin
                  state_d = DISP_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= DISP_IDLE;
         pending_q <= '0;
         hold_q    <= '0;
         dropped_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         hold_q    <= hold_d;
         dropped_q <= dropped_d;
      end
   end

   assign final_fifo_in_ready         = (state_q == DISP_IDLE);
   assign has_flying_messages         = (state_q == DISP_DISPATCH);
   assign master_fifo_in_valid_vector = master_valid;
   assign master_fifo_in_data_vector  = {FIFO_COUNT{sel_payload}};
   assign sc_fifo_in_valid            = sc_valid;
   assign sc_fifo_in_data             = sel_payload;
   assign dropped_count               = dropped_q;

endmodule

// File: tb/tb_final_dispatch_unit.sv
// Directed bench for final_dispatch_unit: default build plus a FIFO_COUNT=2 build for drops.
module tb_final_dispatch_unit;
   import hub_fifo_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [127:0] in_data, in_data2;
   logic         in_valid, in_valid2, in_ready, in_ready2;
   logic [38:0]  m_data;
   logic [2:0]   m_valid, m_ready;
   logic [25:0]  m_data2;
   logic [1:0]   m_valid2, m_ready2;
   logic [12:0]  sc_data, sc_data2;
   logic         sc_valid, sc_valid2, sc_ready, sc_ready2;
   logic         flying, flying2;
   logic [7:0]   dropped, dropped2;

   int compared   = 0;
   int mismatched = 0;

   final_dispatch_unit dut (
      .clk                         (clk),
      .reset                       (reset),
      .final_fifo_in_data          (in_data),
      .final_fifo_in_valid         (in_valid),
      .final_fifo_in_ready         (in_ready),
      .master_fifo_in_data_vector  (m_data),
      .master_fifo_in_valid_vector (m_valid),
      .master_fifo_in_ready_vector (m_ready),
      .sc_fifo_in_data             (sc_data),
      .sc_fifo_in_valid            (sc_valid),
      .sc_fifo_in_ready            (sc_ready),
      .has_flying_messages         (flying),
      .dropped_count               (dropped)
   );

   final_dispatch_unit #(.FIFO_COUNT(2)) dut2 (
      .clk                         (clk),
      .reset                       (reset),
      .final_fifo_in_data          (in_data2),
      .final_fifo_in_valid         (in_valid2),
      .final_fifo_in_ready         (in_ready2),
      .master_fifo_in_data_vector  (m_data2),
      .master_fifo_in_valid_vector (m_valid2),
      .master_fifo_in_ready_vector (m_ready2),
      .sc_fifo_in_data             (sc_data2),
      .sc_fifo_in_valid            (sc_valid2),
      .sc_fifo_in_ready            (sc_ready2),
      .has_flying_messages         (flying2),
      .dropped_count               (dropped2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] mk_slot(input logic [1:0] dest, input logic [12:0] payload);
      slot_t s;
      s.valid   = 1'b1;
      s.dest    = dest;
      s.payload = payload;
      return s;
   endfunction

   initial begin
      logic [127:0] w;
      int           c;

      reset     = 1'b0;
      in_data   = '0;
      in_data2  = '0;
      in_valid  = 1'b0;
      in_valid2 = 1'b0;
      m_ready   = 3'b111;
      m_ready2  = 2'b11;
      sc_ready  = 1'b1;
      sc_ready2 = 1'b1;
      tick();
      tick();
      reset = 1'b1;

      // Reset state
      check("rst_ready_valids", {in_ready, m_valid, sc_valid, flying}, 6'b1_000_0_0);
      check("rst_dropped", dropped, 8'd0);
      check("rst2_state", {in_ready2, m_valid2, sc_valid2, flying2}, 5'b1_00_0_0);
      check("rst2_dropped", dropped2, 8'd0);

      // Slot0 -> master 1, slot3 -> SC
      w = '0;
      w[0 +: 16]  = mk_slot(2'd1, 13'h0AB);
      w[48 +: 16] = mk_slot(2'd3, 13'h1FF);
      in_data = w; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_c1_mvalid", m_valid, 3'b010);
      check("t1_c1_mdata", m_data[25:13], 13'h0AB);
      check("t1_c1_sc_ready_fly", {sc_valid, in_ready, flying}, 3'b001);
      tick();
      check("t1_c2_sc", {sc_valid, sc_data}, {1'b1, 13'h1FF});
      check("t1_c2_mvalid", m_valid, 3'b000);
      tick();
      check("t1_c3_idle", {in_ready, m_valid, sc_valid, flying}, 6'b1_000_0_0);

      // Two slots to channel 0 with channel 0 stalled
      w = '0;
      w[0 +: 16]  = mk_slot(2'd0, 13'h111);
      w[16 +: 16] = mk_slot(2'd0, 13'h222);
      in_data = w; in_valid = 1'b1; m_ready[0] = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t2_stall_hold", {m_valid, m_data[12:0]}, {3'b001, 13'h111});
         tick();
      end
      m_ready[0] = 1'b1;
      check("t2_slot0_deliver", {m_valid, m_data[12:0]}, {3'b001, 13'h111});
      tick();
      check("t2_slot1_deliver", {m_valid, m_data[12:0]}, {3'b001, 13'h222});
      tick();
      check("t2_idle", {in_ready, m_valid, flying}, 5'b1_000_0);

      // FIFO_COUNT=2: slot2 dest 3 dropped, slot5 dest 2 -> SC, slot6 dest 1 -> master 1
      w = '0;
      w[32 +: 16] = mk_slot(2'd3, 13'h055);
      w[80 +: 16] = mk_slot(2'd2, 13'h0CC);
      w[96 +: 16] = mk_slot(2'd1, 13'h033);
      in_data2 = w; in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      check("t3_drop_no_valid", {m_valid2, sc_valid2, flying2}, 4'b00_0_1);
      check("t3_drop_before", dropped2, 8'd0);
      tick();
      check("t3_drop_after", dropped2, 8'd1);
      check("t3_sc", {sc_valid2, sc_data2, m_valid2}, {1'b1, 13'h0CC, 2'b00});
      tick();
      check("t3_master1", {m_valid2, m_data2[25:13]}, {2'b10, 13'h033});
      tick();
      check("t3_idle", {in_ready2, flying2}, 2'b10);

      // 38 words of 8 invalid-dest slots: saturation at 255
      w = '0;
      for (int s = 0; s < 8; s++) w[s*16 +: 16] = mk_slot(2'd3, 13'(s));
      in_data2 = w;
      for (int n = 0; n < 38; n++) begin
         in_valid2 = 1'b1;
         tick();
         in_valid2 = 1'b0;
         c = 0;
         while (!in_ready2 && c < 20) begin
            tick();
            c++;
         end
         check("t4_word_done", in_ready2, 1'b1);
         if (n == 30) check("t4_pre_sat", dropped2, 8'd249);
      end
      check("t4_saturated", dropped2, 8'd255);

      // All-invalid word is consumed without dispatch
      in_data = {8{16'h7FFF}}; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t5_all_invalid", {in_ready, m_valid, sc_valid, flying}, 6'b1_000_0_0);
         tick();
      end

      // Reset on the second dispatch cycle of an 8-slot word
      w = '0;
      for (int s = 0; s < 8; s++) w[s*16 +: 16] = mk_slot(2'(s % 4), 13'(256 + s));
      in_data = w; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t6_slot0", {m_valid, m_data[12:0]}, {3'b001, 13'h100});
      tick();
      check("t6_slot1", {m_valid, m_data[25:13]}, {3'b010, 13'h101});
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("t6_after_reset", {in_ready, m_valid, sc_valid, flying}, 6'b1_000_0_0);
      check("t6_dropped", dropped, 8'd0);
      check("t6_dut2_dropped_clear", dropped2, 8'd0);
      tick();
      check("t6_stays_idle", {in_ready, m_valid, sc_valid, flying}, 6'b1_000_0_0);
      w = '0;
      w[0 +: 16]  = mk_slot(2'd2, 13'h0EE);
      w[16 +: 16] = mk_slot(2'd3, 13'h0DD);
      in_data = w; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t6_next_slot0", {m_valid, m_data[38:26]}, {3'b100, 13'h0EE});
      tick();
      check("t6_next_slot1", {sc_valid, sc_data}, {1'b1, 13'h0DD});
      tick();
      check("t6_next_idle", {in_ready, flying}, 2'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
